timer_scheduler: RTL

Multi-channel millisecond-style event scheduler that shares one tick prescaler among NUM_CHANNELS independent countdown channels, each one-shot or periodic. Sits on the CPU peripheral bus next to the system timer and uses the same edge-triggered request/ready handshake. Merges channel expiries into a pending register and one maskable level interrupt line to the interrupt controller.

---
 rtl/timer_scheduler_pkg.sv | 28 ++
 rtl/timer_scheduler_channel.sv | 66 ++++++
 rtl/timer_scheduler.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/timer_scheduler_pkg.sv
// Shared register map, control-bit positions and channel state type for the timer scheduler.
package timer_scheduler_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] ADDR_PENDING = 5'h00;
    localparam logic [ADDR_W-1:0] ADDR_MASK    = 5'h01;
    localparam logic [ADDR_W-1:0] ADDR_ACTIVE  = 5'h02;
    localparam logic [ADDR_W-1:0] ADDR_CH_BASE = 5'h08;

    localparam int unsigned CH_STRIDE = 4;

    localparam logic [1:0] CH_CTRL   = 2'd0;
    localparam logic [1:0] CH_RELOAD = 2'd1;
    localparam logic [1:0] CH_COUNT  = 2'd2;

    localparam int unsigned CTRL_EN_BIT       = 0;
    localparam int unsigned CTRL_PERIODIC_BIT = 1;

    typedef struct packed {
        logic              en;
        logic              periodic;
        logic [DATA_W-1:0] reload;
        logic [DATA_W-1:0] count;
    } ch_state_t;

endpackage

// File: rtl/timer_scheduler_channel.sv
// One countdown channel: CTRL/RELOAD/COUNT storage, tick-driven countdown and expiry pulse.
module timer_scheduler_channel
    import timer_scheduler_pkg::*;
(
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              tick,
    input  logic              wr_ctrl,
    input  logic              wr_reload,
    input  logic              wr_count,
    input  logic [DATA_W-1:0] wdata,
    output ch_state_t         state,
    output logic              fire_c
);

    ch_state_t state_n;
    logic      expire_c;

    // A zero count on a running channel expires like a count of one.
    always_comb begin
        state_n  = state;
        expire_c = state.en && (state.count <= DATA_W'(1));
        fire_c   = tick && expire_c && !wr_ctrl && !wr_count;

        if (tick && state.en) begin
            if (expire_c) begin
                if (state.periodic) begin
                    state_n.count = state.reload;
                end else begin
                    state_n.count = '0;
                    state_n.en    = 1'b0;
                end
            end else begin
                state_n.count = state.count - DATA_W'(1);
            end
        end

        if (wr_reload) begin
            state_n.reload = wdata;
        end

        // CPU writes to CTRL/COUNT override the tick update of the same cycle.
        if (wr_ctrl) begin
            state_n.periodic = wdata[CTRL_PERIODIC_BIT];
            if (wdata[CTRL_EN_BIT]) begin
                state_n.count = state.reload;
                state_n.en    = (state.reload != '0);
            end else begin
                state_n.en = 1'b0;
            end
        end

        if (wr_count) begin
            state_n.count = wdata;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= '0;
        end else begin
            state <= state_n;
        end
    end

endmodule

// File: rtl/timer_scheduler.sv
// Multi-channel tick scheduler: shared prescaler, bus register file, pending/mask and interrupt.
module timer_scheduler
    import timer_scheduler_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned TICK_DIV     = 1000
)
(
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_request,
    input  logic              i_rw,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_ready,
    output logic              o_interrupt,
    output logic              o_tick
);

    localparam int unsigned      PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]        prescale_q;
    logic [PRE_W-1:0]        prescale_n;
    logic                    tick_q;
    logic                    request_q;
    logic [NUM_CHANNELS-1:0] pending_q;
    logic [NUM_CHANNELS-1:0] pending_n;
    logic [NUM_CHANNELS-1:0] mask_q;

    logic                    access_c;
    logic                    write_c;
    logic                    ch_hit_c;
    logic [ADDR_W-1:0]       ch_off_c;
    logic [2:0]              ch_idx_c;
    logic [1:0]              reg_off_c;
    logic [DATA_W-1:0]       rdata_c;
    logic [NUM_CHANNELS-1:0] w1c_c;
    logic [NUM_CHANNELS-1:0] active_c;
    logic [NUM_CHANNELS-1:0] wr_ctrl_c;
    logic [NUM_CHANNELS-1:0] wr_reload_c;
    logic [NUM_CHANNELS-1:0] wr_count_c;
    logic [NUM_CHANNELS-1:0] fire_c;
    ch_state_t               ch_state [NUM_CHANNELS];

    always_comb begin
        prescale_n = (prescale_q == PRE_LAST) ? '0 : prescale_q + PRE_W'(1);
    end

    // Bus decode: access only on a rising request edge.
    always_comb begin
        access_c  = i_request && !request_q;
        write_c   = access_c && i_rw;
        ch_hit_c  = (i_address >= ADDR_CH_BASE);
        ch_off_c  = i_address - ADDR_CH_BASE;
        ch_idx_c  = 3'(ch_off_c / ADDR_W'(CH_STRIDE));
        reg_off_c = ch_off_c[1:0];
        w1c_c     = (write_c && (i_address == ADDR_PENDING)) ? i_wdata[NUM_CHANNELS-1:0] : '0;
        wr_ctrl_c   = '0;
        wr_reload_c = '0;
        wr_count_c  = '0;
        active_c    = '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            active_c[c] = ch_state[c].en;
            if (write_c && ch_hit_c && (ch_idx_c == 3'(c))) begin
                wr_ctrl_c[c]   = (reg_off_c == CH_CTRL);
                wr_reload_c[c] = (reg_off_c == CH_RELOAD);
                wr_count_c[c]  = (reg_off_c == CH_COUNT);
            end
        end
    end

    // Read mux; unmapped addresses and absent channels read zero.
    always_comb begin
        rdata_c = '0;
        case (i_address)
            ADDR_PENDING: rdata_c = DATA_W'(pending_q);
            ADDR_MASK:    rdata_c = DATA_W'(mask_q);
            ADDR_ACTIVE:  rdata_c = DATA_W'(active_c);
            default: begin
                for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                    if (ch_hit_c && (ch_idx_c == 3'(c))) begin
                        case (reg_off_c)
                            CH_CTRL: begin
                                rdata_c[CTRL_EN_BIT]       = ch_state[c].en;
                                rdata_c[CTRL_PERIODIC_BIT] = ch_state[c].periodic;
                            end
                            CH_RELOAD: rdata_c = ch_state[c].reload;
                            CH_COUNT:  rdata_c = ch_state[c].count;
                            default:   rdata_c = '0;
                        endcase
                    end
                end
            end
        endcase
    end

    // Hardware expiry beats a same-cycle W1C of the same bit.
    always_comb begin
        pending_n = (pending_q & ~w1c_c) | fire_c;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            prescale_q  <= '0;
            tick_q      <= 1'b0;
            request_q   <= 1'b0;
            pending_q   <= '0;
            mask_q      <= '0;
            o_interrupt <= 1'b0;
            o_ready     <= 1'b0;
            o_rdata     <= '0;
        end else begin
            prescale_q  <= prescale_n;
            tick_q      <= (prescale_n == PRE_LAST);
            request_q   <= i_request;
            pending_q   <= pending_n;
            o_interrupt <= |(pending_q & mask_q);
            if (write_c && (i_address == ADDR_MASK)) begin
                mask_q <= i_wdata[NUM_CHANNELS-1:0];
            end
            if (access_c) begin
                o_ready <= 1'b1;
                o_rdata <= rdata_c;
            end else if (!i_request) begin
                o_ready <= 1'b0;
            end
        end
    end

    assign o_tick = tick_q;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        timer_scheduler_channel u_channel (
            .i_clock   (i_clock),
            .i_reset   (i_reset),
            .tick      (tick_q),
            .wr_ctrl   (wr_ctrl_c[c]),
            .wr_reload (wr_reload_c[c]),
            .wr_count  (wr_count_c[c]),
            .wdata     (i_wdata),
            .state     (ch_state[c]),
            .fire_c    (fire_c[c])
        );
    end

endmodule
